// File: rtl/countdown_ctrl_if.sv
// rtl/countdown_ctrl_if.sv - control/status bundle between the countdown sequencer and its environment
interface countdown_ctrl_if;
  logic       vsync_in;
  logic       start_in;
  logic       abort_in;
  logic [1:0] digit_out;
  logic       countdown_active;
  logic       digit_visible;
  logic       game_start;
  logic       game_run;

  modport master (
    output vsync_in, start_in, abort_in,
    input  digit_out, countdown_active, digit_visible, game_start, game_run
  );

  modport slave (
    input  vsync_in, start_in, abort_in,
    output digit_out, countdown_active, digit_visible, game_start, game_run
  );
endinterface

// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - 3-2-1 start-screen countdown sequenced on vsync rising edges
// Optional macro COUNTDOWN_BLINK_EN blanks the glyph for the last quarter of each digit.
module countdown_ctrl #(
  parameter int FRAMES_PER_DIGIT = 60,
  parameter int CNT_W            = 8
) (
  input logic             pclk,
  input logic             reset,
  countdown_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_C3   = 3'd1;
  localparam logic [2:0] S_C2   = 3'd2;
  localparam logic [2:0] S_C1   = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_DIGIT - 1);

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] frame_cnt, cnt_nxt;
  logic             vsync_d, start_d;
  logic             frame_tick, start_edge;
  logic [1:0]       digit_nxt;
  logic             active_nxt;
  logic             visible_nxt;

  assign frame_tick = bus.vsync_in & ~vsync_d;
  assign start_edge = bus.start_in & ~start_d;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = frame_cnt;
    if (bus.abort_in) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            state_nxt = S_C3;
            cnt_nxt   = '0;
          end
        end
        S_C3, S_C2, S_C1: begin
          if (frame_tick) begin
            if (frame_cnt == CNT_LAST) begin
              cnt_nxt = '0;
              case (state)
                S_C3:    state_nxt = S_C2;
                S_C2:    state_nxt = S_C1;
                default: state_nxt = S_RUN;
              endcase
            end else begin
              cnt_nxt = frame_cnt + 1'b1;
            end
          end
        end
        S_RUN:   state_nxt = S_RUN;
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    digit_nxt = 2'd0;
    case (state_nxt)
      S_C3:    digit_nxt = 2'd3;
      S_C2:    digit_nxt = 2'd2;
      S_C1:    digit_nxt = 2'd1;
      default: digit_nxt = 2'd0;
    endcase
  end

  assign active_nxt = (state_nxt == S_C3) || (state_nxt == S_C2) || (state_nxt == S_C1);

`ifdef COUNTDOWN_BLINK_EN
  localparam logic [CNT_W-1:0] VIS_LIMIT = CNT_W'(FRAMES_PER_DIGIT - FRAMES_PER_DIGIT / 4);
  assign visible_nxt = active_nxt && (cnt_nxt < VIS_LIMIT);
`else
  assign visible_nxt = active_nxt;
`endif

  // Edge-detect history resets high so a level already asserted at release is not an event.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      vsync_d              <= 1'b1;
      start_d              <= 1'b1;
      state                <= S_IDLE;
      frame_cnt            <= '0;
      bus.digit_out        <= 2'd0;
      bus.countdown_active <= 1'b0;
      bus.digit_visible    <= 1'b0;
      bus.game_start       <= 1'b0;
      bus.game_run         <= 1'b0;
    end else begin
      vsync_d              <= bus.vsync_in;
      start_d              <= bus.start_in;
      state                <= state_nxt;
      frame_cnt            <= cnt_nxt;
      bus.digit_out        <= digit_nxt;
      bus.countdown_active <= active_nxt;
      bus.digit_visible    <= visible_nxt;
      bus.game_start       <= (state == S_C1) && (state_nxt == S_RUN);
      bus.game_run         <= (state_nxt == S_RUN);
    end
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb/tb_countdown_ctrl.sv - directed and random checks of countdown_ctrl against a tick-count model
module tb_countdown_ctrl;

  localparam int F     = 4;
  localparam int TOTAL = 3 * F;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  countdown_ctrl_if bus ();

  countdown_ctrl #(.FRAMES_PER_DIGIT(F), .CNT_W(8)) dut (
    .pclk  (pclk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 pclk = ~pclk;

  // Model: a countdown is "running" since its start, and the digit shown follows from
  // how many vsync edges have elapsed since then.
  bit   m_running = 1'b0;
  int   m_ticks   = 0;
  logic m_vprev   = 1'b1;
  logic m_sprev   = 1'b1;
  bit   exp_gs    = 1'b0;
  logic s_lvl     = 1'b0;
  int   gs_count  = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    bit   act;
    logic [1:0] dig;
    bit   vis;
    act = m_running && (m_ticks < TOTAL);
    dig = act ? 2'(3 - m_ticks / F) : 2'd0;
`ifdef COUNTDOWN_BLINK_EN
    vis = act && ((m_ticks % F) < (F - F / 4));
`else
    vis = act;
`endif
    check("digit_out", 8'(bus.digit_out), 8'(dig));
    check("countdown_active", 8'(bus.countdown_active), 8'(act));
    check("digit_visible", 8'(bus.digit_visible), 8'(vis));
    check("game_run", 8'(bus.game_run), 8'(m_running && (m_ticks >= TOTAL)));
    check("game_start", 8'(bus.game_start), 8'(exp_gs));
    if (bus.game_start === 1'b1) gs_count++;
  endtask

  task automatic step(input logic v, input logic s, input logic a);
    bit tick, sedge;
    bus.vsync_in = v;
    bus.start_in = s;
    bus.abort_in = a;
    s_lvl = s;
    @(posedge pclk);
    tick    = v && !m_vprev;
    sedge   = s && !m_sprev;
    m_vprev = v;
    m_sprev = s;
    exp_gs  = 1'b0;
    if (a) begin
      m_running = 1'b0;
      m_ticks   = 0;
    end else if (!m_running) begin
      if (sedge) begin
        m_running = 1'b1;
        m_ticks   = 0;
      end
    end else if (tick && m_ticks < TOTAL) begin
      m_ticks++;
      exp_gs = (m_ticks == TOTAL);
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input logic v, input logic s);
    bus.vsync_in = v;
    bus.start_in = s;
    bus.abort_in = 1'b0;
    s_lvl = s;
    rst_n = 1'b0;
    #1;
    m_running = 1'b0;
    m_ticks   = 0;
    m_vprev   = 1'b1;
    m_sprev   = 1'b1;
    exp_gs    = 1'b0;
    check_outputs();
    repeat (2) @(posedge pclk);
    #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  task automatic vs_pulse(input int low_cycles);
    step(1'b1, s_lvl, 1'b0);
    for (int i = 0; i < low_cycles; i++) step(1'b0, s_lvl, 1'b0);
  endtask

  task automatic start_pulse();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    bus.vsync_in = 1'b1;
    bus.start_in = 1'b1;
    bus.abort_in = 1'b0;

    // Start-up with start and vsync already high: no countdown until start re-rises.
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
    end
    check("idle_after_startup", 8'(bus.countdown_active), 8'd0);
    step(1'b0, 1'b1, 1'b0);

    // Full sequence with variable frame spacing; extra starts are ignored.
    gs_count = 0;
    start_pulse();
    check("c3_entered", 8'(bus.digit_out), 8'd3);
    for (int i = 0; i < TOTAL; i++) begin
      vs_pulse(1 + (i % 3));
      if (i == 1) start_pulse();
    end
    for (int i = 0; i < 3; i++) begin
      start_pulse();
      vs_pulse(2);
    end
    check("one_game_start", 8'(gs_count), 8'd1);
    check("run_held", 8'(bus.game_run), 8'd1);

    // Abort in C2 after two ticks, then a fresh full C3.
    step(1'b0, 1'b0, 1'b1);
    start_pulse();
    for (int i = 0; i < F + 2; i++) vs_pulse(1);
    check("in_c2", 8'(bus.digit_out), 8'd2);
    step(1'b0, s_lvl, 1'b1);
    check("abort_digit", 8'(bus.digit_out), 8'd0);
    start_pulse();
    for (int i = 0; i < F - 1; i++) vs_pulse(1);
    check("c3_full_after_abort", 8'(bus.digit_out), 8'd3);
    vs_pulse(1);
    check("c2_after_abort", 8'(bus.digit_out), 8'd2);

    // Abort coincident with start in IDLE.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check("abort_beats_start", 8'(bus.countdown_active), 8'd0);

    // Abort coincident with the final C1 tick: no game_start.
    gs_count = 0;
    start_pulse();
    for (int i = 0; i < TOTAL - 1; i++) vs_pulse(1);
    check("in_c1", 8'(bus.digit_out), 8'd1);
    step(1'b1, s_lvl, 1'b1);
    step(1'b0, s_lvl, 1'b0);
    check("no_gs_on_abort", 8'(gs_count), 8'd0);

    // Reset mid-countdown.
    start_pulse();
    vs_pulse(2);
    do_reset(1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic v, s, a;
      v = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 3) == 0) ? ~s_lvl : s_lvl;
      a = ($urandom_range(0, 59) == 0);
      if (i == 1500) begin
        do_reset(v, s);
      end else begin
        step(v, s, a);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
